// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment pattern table and scan decoder FSM states
package seg_pkg;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Nibble written for any pattern outside the 0-9 table
    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_to_digit.sv
// rtl/seg_to_digit.sv - inverse lookup from active-low segment pattern to digit nibble
module seg_to_digit
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       ok
);

    // Map each legal pattern back to its digit; anything else is flagged invalid
    always_comb begin
        nibble = DIGIT_INVALID;
        ok     = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'd0;
            SEG_1:   nibble = 4'd1;
            SEG_2:   nibble = 4'd2;
            SEG_3:   nibble = 4'd3;
            SEG_4:   nibble = 4'd4;
            SEG_5:   nibble = 4'd5;
            SEG_6:   nibble = 4'd6;
            SEG_7:   nibble = 4'd7;
            SEG_8:   nibble = 4'd8;
            SEG_9:   nibble = 4'd9;
            default: begin
                nibble = DIGIT_INVALID;
                ok     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - deglitching readback of a multiplexed 7-segment display bus
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    frame_valid,
    output logic                    pattern_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam int LC_W  = $clog2(NUM_DIGITS + 1);

    // Capture fires when the counter shows STABLE_CYCLES-1 equal samples behind
    // the current one; the counter is cleared on the edge that sees the change.
    localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   an_p;
    logic [6:0]              seg_p;
    logic [CNT_W-1:0]        cnt;
    scan_state_t             state;

    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   shadow_ok;

    logic [NUM_DIGITS-1:0]   mask_next;
    logic [4*NUM_DIGITS-1:0] shadow_next;
    logic [NUM_DIGITS-1:0]   shadow_ok_next;

    logic [LC_W-1:0]         low_cnt;
    logic                    blank;
    logic                    single;
    logic                    multi;
    logic                    changed;
    logic                    capture;
    logic                    frame_done;
    logic [3:0]              dec_nibble;
    logic                    dec_ok;

    seg_to_digit u_seg_to_digit (
        .seg    (seg_s),
        .nibble (dec_nibble),
        .ok     (dec_ok)
    );

    // Input sample register, previous sample and saturating stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s  <= '1;
            seg_s <= SEG_BLANK;
            an_p  <= '1;
            seg_p <= SEG_BLANK;
            cnt   <= '0;
        end else begin
            an_s  <= an;
            seg_s <= seg;
            an_p  <= an_s;
            seg_p <= seg_s;
            if (changed) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Classify the sampled anodes: blank, exactly one position, or several
    always_comb begin
        low_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s[i]) begin
                low_cnt = low_cnt + LC_W'(1);
            end
        end
    end

    assign blank   = (low_cnt == '0);
    assign single  = (low_cnt == LC_W'(1));
    assign multi   = (low_cnt > LC_W'(1));
    assign changed = (an_s != an_p) || (seg_s != seg_p);
    assign capture = (state == SETTLE) && !blank && !changed && (cnt == CNT_CAPTURE);

    // Next shadow/mask contents if this cycle captures a single-position pattern
    always_comb begin
        mask_next      = mask;
        shadow_next    = shadow;
        shadow_ok_next = shadow_ok;
        if (capture && single) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (!an_s[i]) begin
                    mask_next[i]          = 1'b1;
                    shadow_next[4*i +: 4] = dec_nibble;
                    shadow_ok_next[i]     = dec_ok;
                end
            end
        end
    end

    assign frame_done = capture && single && (&mask_next);

    // Scan FSM, shadow/mask bookkeeping and registered frame outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            shadow      <= '0;
            shadow_ok   <= '0;
            digits      <= '0;
            digit_ok    <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            if (blank) begin
                state <= IDLE;
            end else if (changed || state == IDLE) begin
                state <= SETTLE;
            end else if (capture) begin
                state <= HELD;
            end

            shadow      <= shadow_next;
            shadow_ok   <= shadow_ok_next;
            frame_valid <= frame_done;
            pattern_err <= capture && (multi || !dec_ok);

            if (frame_done) begin
                digits   <= shadow_next;
                digit_ok <= shadow_ok_next;
                mask     <= '0;
            end else begin
                mask     <= mask_next;
            end
        end
    end

endmodule
